// File: rtl/fifo_pkg.sv
// Shared constants, sizing helper and pointer type for the fifo_buf slice.
package fifo_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  // Ceiling log2, usable in constant expressions for port and array sizing.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  localparam int unsigned AW = clog2(DEPTH);

  // Read/write pointers carry one extra wrap bit so full and empty differ.
  typedef logic [AW:0] ptr_t;

endpackage

// File: rtl/fifo_if.sv
// req/ack handshake bundle; ws/rs are the FIFO-side views, wm/rm the peers.
interface fifo_if import fifo_pkg::*; #(
  parameter int unsigned dw = DW
);

  logic [dw-1:0] data;
  logic          req;
  logic          ack;

  modport ws (input  data, input  req, output ack);
  modport rs (output data, output req, input  ack);
  modport wm (output data, output req, input  ack);
  modport rm (input  data, input  req, output ack);

endinterface

// File: rtl/fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram import fifo_pkg::*; #(
  parameter  int unsigned dw    = DW,
  parameter  int unsigned depth = DEPTH,
  localparam int unsigned aw    = clog2(depth)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] rdata_c
);

  logic [dw-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/fifo_buf.sv
// First-word-fall-through synchronous FIFO with registered level/almost-full status.
module fifo_buf import fifo_pkg::*; #(
  parameter  int unsigned dw       = DW,
  parameter  int unsigned depth    = DEPTH,
  parameter  int unsigned afull_th = 12,
  localparam int unsigned aw       = clog2(depth)
) (
  input  logic    clk,
  input  logic    rstn,
  fifo_if.ws      w_if,
  fifo_if.rs      r_if,
  output logic [aw:0] level,
  output logic    afull
);

  localparam int unsigned LW = aw + 1;

  logic [aw:0] wp_q, wp_d;
  logic [aw:0] rp_q, rp_d;
  logic [aw:0] level_q, level_d;
  logic        afull_q, afull_d;
  logic        rstn_q, rstn_d;
  logic        w_ack_c, r_req_c, wr_en_c, rd_en_c;
  logic [dw-1:0] rdata_c;

  // Handshake decode from registered state only; rstn_q holds off writes one cycle past reset.
  assign w_ack_c = rstn_q & (level_q != LW'(depth));
  assign r_req_c = (level_q != '0);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    rstn_d  = 1'b1;
    wr_en_c = w_if.req & w_ack_c;
    rd_en_c = r_if.ack & r_req_c;
    if (wr_en_c) wp_d = wp_q + LW'(1);
    if (rd_en_c) rp_d = rp_q + LW'(1);
    level_d = wp_d - rp_d;
    afull_d = (level_d >= LW'(afull_th));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      afull_q <= 1'b0;
      rstn_q  <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      afull_q <= afull_d;
      rstn_q  <= rstn_d;
    end
  end

  fifo_ram #(
    .dw    (dw),
    .depth (depth)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en_c),
    .waddr   (wp_q[aw-1:0]),
    .wdata   (w_if.data),
    .raddr   (rp_q[aw-1:0]),
    .rdata_c (rdata_c)
  );

  assign w_if.ack  = w_ack_c;
  assign r_if.req  = r_req_c;
  assign r_if.data = rdata_c;
  assign level     = level_q;
  assign afull     = afull_q;

endmodule

// File: tb/tb_fifo_buf.sv
// Self-checking bench for fifo_buf: fill table, scoreboard on every read transfer, corner sequences.
module tb_fifo_buf;

  logic       clk;
  logic       rstn;
  logic [4:0] level;
  logic       afull;

  fifo_if #(.dw(8)) w_if ();
  fifo_if #(.dw(8)) r_if ();

  fifo_buf #(.dw(8), .depth(16), .afull_th(12)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .w_if  (w_if),
    .r_if  (r_if),
    .level (level),
    .afull (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w_req;
    logic [7:0] w_data;
    logic       r_ack;
    logic       e_w_ack;
    logic       e_r_req;
    logic [4:0] e_level;
    logic       e_afull;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t       fill_tab [17];
  logic [7:0] exp_q [$];
  int         checks;
  int         failures;
  int         rd_cnt;
  int         max_lvl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample the handshake just before the edge, then update the scoreboard.
  task automatic step();
    logic       rs, wr, rd;
    logic [7:0] wd, rdat;
    rs   = rstn;
    wr   = w_if.req & w_if.ack;
    wd   = w_if.data;
    rd   = r_if.req & r_if.ack;
    rdat = r_if.data;
    @(posedge clk);
    #1;
    if (rs !== 1'b1) begin
      exp_q.delete();
    end else begin
      if (rd === 1'b1) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("sb_data", 32'(rdat), 32'(exp_q.pop_front()));
        rd_cnt++;
      end
      if (wr === 1'b1) exp_q.push_back(wd);
    end
    if (32'(level) > 32'(max_lvl)) max_lvl = int'(level);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int sent, cyc, rd_start;
    logic acc;
    checks   = 0;
    failures = 0;
    rd_cnt   = 0;
    max_lvl  = 0;

    for (int i = 0; i < 16; i++) begin
      fill_tab[i] = '{w_req: 1'b1, w_data: 8'(i), r_ack: 1'b0,
                      e_w_ack: (i != 15), e_r_req: 1'b1, e_level: 5'(i + 1),
                      e_afull: (i + 1 >= 12), e_rdata: 8'h00};
    end
    fill_tab[16] = '{w_req: 1'b1, w_data: 8'h10, r_ack: 1'b0, e_w_ack: 1'b0,
                     e_r_req: 1'b1, e_level: 5'd16, e_afull: 1'b1, e_rdata: 8'h00};

    // Reset held with a pending write
    rstn = 1'b0; w_if.req = 1'b1; w_if.data = 8'h77; r_if.ack = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_w_ack", 32'(w_if.ack), 32'd0);
      chk("rst_r_req", 32'(r_if.req), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_afull", 32'(afull), 32'd0);
    end
    rstn = 1'b1;
    chk("rel_w_ack_c0", 32'(w_if.ack), 32'd0);
    step();
    chk("rel_w_ack_c1", 32'(w_if.ack), 32'd1);
    chk("rel_level_c1", 32'(level), 32'd0);
    step();
    chk("first_wr_level", 32'(level), 32'd1);
    chk("first_wr_r_req", 32'(r_if.req), 32'd1);
    chk("first_wr_rdata", 32'(r_if.data), 32'h77);
    w_if.req = 1'b0; r_if.ack = 1'b1;
    step();
    r_if.ack = 1'b0;
    chk("first_rd_level", 32'(level), 32'd0);

    // Fill from empty, 17th write held
    for (int i = 0; i < 17; i++) begin
      w_if.req = fill_tab[i].w_req; w_if.data = fill_tab[i].w_data; r_if.ack = fill_tab[i].r_ack;
      step();
      chk("fill_w_ack", 32'(w_if.ack), 32'(fill_tab[i].e_w_ack));
      chk("fill_r_req", 32'(r_if.req), 32'(fill_tab[i].e_r_req));
      chk("fill_level", 32'(level), 32'(fill_tab[i].e_level));
      chk("fill_afull", 32'(afull), 32'(fill_tab[i].e_afull));
      chk("fill_rdata", 32'(r_if.data), 32'(fill_tab[i].e_rdata));
    end

    // Simultaneous read+write on full: write stalls one cycle
    r_if.ack = 1'b1;
    step();
    chk("full_rw_level", 32'(level), 32'd15);
    chk("full_rw_w_ack", 32'(w_if.ack), 32'd1);
    chk("full_rw_rdata", 32'(r_if.data), 32'h01);
    r_if.ack = 1'b0;
    step();
    chk("full_rw_level2", 32'(level), 32'd16);
    chk("full_rw_w_ack2", 32'(w_if.ack), 32'd0);
    w_if.req = 1'b0;

    r_if.ack = 1'b1;
    for (int i = 0; i < 16; i++) step();
    r_if.ack = 1'b0;
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_r_req", 32'(r_if.req), 32'd0);
    chk("drain_afull", 32'(afull), 32'd0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // Write into empty with r_ack held
    r_if.ack = 1'b1; w_if.req = 1'b1; w_if.data = 8'hA5;
    step();
    w_if.req = 1'b0;
    chk("empty_r_req", 32'(r_if.req), 32'd1);
    chk("empty_rdata", 32'(r_if.data), 32'hA5);
    chk("empty_level", 32'(level), 32'd1);
    step();
    r_if.ack = 1'b0;
    chk("empty_r_req2", 32'(r_if.req), 32'd0);
    chk("empty_level2", 32'(level), 32'd0);

    // 40-word stream with random back-pressure across pointer wrap
    sent = 0; cyc = 0; max_lvl = 0; rd_start = rd_cnt;
    w_if.req = 1'b1; w_if.data = 8'($urandom);
    while ((sent < 40 || level != 5'd0) && cyc < 2000) begin
      r_if.ack = 1'($urandom_range(0, 1));
      acc = w_if.req & w_if.ack;
      step();
      cyc++;
      if (acc === 1'b1) begin
        sent++;
        if (sent < 40) w_if.data = 8'($urandom);
        else           w_if.req  = 1'b0;
      end
    end
    r_if.ack = 1'b0;
    chk("wrap_no_timeout", 32'(cyc < 2000), 32'd1);
    chk("wrap_rd_count", 32'(rd_cnt - rd_start), 32'd40);
    chk("wrap_max_level", 32'(max_lvl <= 16), 32'd1);
    chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a stream
    w_if.req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      w_if.data = 8'(8'h30 + i);
      step();
    end
    w_if.req = 1'b0;
    chk("mid_pre_level", 32'(level), 32'd7);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_r_req", 32'(r_if.req), 32'd0);
    chk("mid_rst_w_ack", 32'(w_if.ack), 32'd0);
    chk("mid_rst_afull", 32'(afull), 32'd0);
    step();
    chk("mid_rel_w_ack", 32'(w_if.ack), 32'd1);
    w_if.req = 1'b1; w_if.data = 8'h11;
    step();
    w_if.data = 8'h22;
    step();
    w_if.req = 1'b0;
    chk("mid_wr_level", 32'(level), 32'd2);
    chk("mid_head", 32'(r_if.data), 32'h11);
    rd_start = rd_cnt;
    r_if.ack = 1'b1;
    step();
    step();
    r_if.ack = 1'b0;
    chk("mid_rd_count", 32'(rd_cnt - rd_start), 32'd2);
    chk("mid_end_level", 32'(level), 32'd0);
    chk("mid_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
